// File: rtl/lsu_pkg.sv
// Shared types and access-width helpers for the load/store unit.
// Used by lsu_ctrl and lsu_ld_align.
package lsu_pkg;

   localparam int BUS_W = 32;
   localparam int BE_W  = BUS_W / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } lsu_state_e;

   // Legal width for the op kind and naturally aligned address.
   function automatic logic acc_ok(input logic st, input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B:    return 1'b1;
         F3_H:    return !a[0];
         F3_W:    return a == 2'b00;
         F3_BU:   return !st;
         F3_HU:   return !st && !a[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [BE_W-1:0] acc_be(input logic [1:0] sz, input logic [1:0] lane);
      case (sz)
         2'b00:   return 4'b0001 << lane;
         2'b01:   return 4'b0011 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [BUS_W-1:0] acc_wdata(input logic [1:0] sz, input logic [BUS_W-1:0] d);
      case (sz)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load data alignment: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it according to funct3.
module lsu_ld_align
   import lsu_pkg::*;
(
   input  logic [BUS_W-1:0] rdata,
   input  logic [1:0]       lane,
   input  logic [2:0]       funct3,
   output logic [BUS_W-1:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b    = rdata[{lane, 3'b000} +: 8];
      h    = lane[1] ? rdata[31:16] : rdata[15:0];
      data = '0;
      case (funct3)
         F3_B:    data = {{24{b[7]}}, b};
         F3_H:    data = {{16{h[15]}}, h};
         F3_W:    data = rdata;
         F3_BU:   data = {24'd0, b};
         F3_HU:   data = {16'd0, h};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE -> ACCESS -> DONE bus sequencer.
// Define LSU_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC ack-less cycles.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_mem_rd,
   input  logic             i_mem_wren,
   input  logic [2:0]       i_funct3,
   input  logic [BUS_W-1:0] i_addr,
   input  logic [BUS_W-1:0] i_st_data,
   output logic             o_bus_req,
   output logic             o_bus_we,
   output logic [BUS_W-1:0] o_bus_addr,
   output logic [BE_W-1:0]  o_bus_be,
   output logic [BUS_W-1:0] o_bus_wdata,
   input  logic             i_bus_ack,
   input  logic [BUS_W-1:0] i_bus_rdata,
   output logic             o_stall,
   output logic             o_ld_vld,
   output logic [BUS_W-1:0] o_ld_data,
   output logic             o_lsu_exc
);

   lsu_state_e       state_q, state_d;
   logic [BUS_W-1:0] addr_q, wdata_q, rdata_q, ld_aligned;
   logic [BE_W-1:0]  be_q;
   logic [2:0]       f3_q;
   logic [1:0]       lane_q;
   logic             we_q, ld_q, exc_q;
   logic             req, ok, to_hit;

   assign req = i_mem_rd | i_mem_wren;
   // Store wins when both strobes are high.
   assign ok  = acc_ok(i_mem_wren, i_funct3, i_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                  to_cnt_q <= '0;
      else if (state_q != ST_ACCESS) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + 1'b1;
   end

   assign to_hit = (state_q == ST_ACCESS) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
   assign to_hit = 1'b0;
   // TIMEOUT_CYC only matters with the timeout counter built in.
   if (TIMEOUT_CYC < 1) begin : g_timeout_unused
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         f3_q    <= '0;
         lane_q  <= '0;
         we_q    <= 1'b0;
         ld_q    <= 1'b0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req) begin
            addr_q  <= {i_addr[31:2], 2'b00};
            be_q    <= acc_be(i_funct3[1:0], i_addr[1:0]);
            wdata_q <= acc_wdata(i_funct3[1:0], i_st_data);
            rdata_q <= '0;
            f3_q    <= i_funct3;
            lane_q  <= i_addr[1:0];
            we_q    <= i_mem_wren;
            ld_q    <= !i_mem_wren;
            exc_q   <= !ok;
         end else if (state_q == ST_ACCESS) begin
            if (i_bus_ack)   rdata_q <= i_bus_rdata;
            else if (to_hit) exc_q   <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      o_stall   = 1'b0;
      o_bus_req = 1'b0;
      o_bus_we  = 1'b0;
      o_ld_vld  = 1'b0;
      o_lsu_exc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               o_stall = 1'b1;
               state_d = ok ? ST_ACCESS : ST_DONE;
            end
         end
         ST_ACCESS: begin
            o_stall   = 1'b1;
            o_bus_req = 1'b1;
            o_bus_we  = we_q;
            if (i_bus_ack || to_hit) state_d = ST_DONE;
         end
         ST_DONE: begin
            o_ld_vld  = ld_q & ~exc_q;
            o_lsu_exc = exc_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_bus_addr  = addr_q;
   assign o_bus_be    = be_q;
   assign o_bus_wdata = wdata_q;
   assign o_ld_data   = o_ld_vld ? ld_aligned : '0;

   lsu_ld_align u_ld_align (
      .rdata  (rdata_q),
      .lane   (lane_q),
      .funct3 (f3_q),
      .data   (ld_aligned)
   );

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning bus-ack timeout in ACCESS cycles (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL use one clock and an asynchronous, active-low reset: i_clk  in  1  clock, rising edge; i_rst_n  in  1  async reset, active low.
REQ-003 SHALL have i_mem_rd  in  1  current instruction is a load.
REQ-004 SHALL have i_mem_wren  in  1  current instruction is a store.
REQ-005 SHALL have i_funct3  in  3  instruction funct3 (access width/sign).
REQ-006 SHALL have i_addr  in  32  ALU-computed byte address.
REQ-007 SHALL have i_st_data  in  32  rs2 store data.
REQ-008 SHALL have o_bus_req, o_bus_we  out  1 each  bus request, write strobe.
REQ-009 SHALL have o_bus_addr  out  32  word address ({i_addr[31:2],2'b00}).
REQ-010 SHALL have o_bus_be  out  4, o_bus_wdata  out  32  byte enables, lane-replicated write data.
REQ-011 SHALL have i_bus_ack  in  1, i_bus_rdata  in  32  bus completion, read word.
REQ-012 SHALL have o_stall  out  1  hold PC/regfile write.
REQ-013 SHALL have o_ld_vld  out  1, o_ld_data  out  32  load result valid, aligned/extended data.
REQ-014 SHALL have o_lsu_exc  out  1  misaligned, illegal width or timeout.

Function
REQ-015 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-016 IDLE: on i_mem_rd|i_mem_wren, legal and aligned -> ACCESS, latching addr, be, wdata, we; illegal/misaligned -> DONE with exception flag set, no bus access.
REQ-017 ACCESS: o_bus_req=1 every cycle, outputs held stable; on i_bus_ack capture i_bus_rdata, -> DONE.
REQ-018 DONE: o_stall=0, o_ld_vld=1 for loads without exception, o_lsu_exc per latched flag; always -> IDLE next cycle.
REQ-019 o_stall SHALL be combinational: (IDLE & (i_mem_rd|i_mem_wren)) | ACCESS.
REQ-020 Minimum memory-op latency 3 cycles (IDLE, ACCESS with ack, DONE); each ack-less ACCESS cycle adds one.
REQ-021 Widths: funct3 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (loads); stores 000/001/010 only; other codes illegal.
REQ-022 be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-023 wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
REQ-024 Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
REQ-025 Load data: select lane by addr[1:0], sign-extend (000/001) or zero-extend (100/101); o_ld_data=0 when exception.
REQ-026 i_mem_rd and i_mem_wren both high: store SHALL take priority.
REQ-027 i_bus_ack outside ACCESS SHALL be ignored.
REQ-028 o_bus_req, o_bus_we SHALL be 0 outside ACCESS.

Reset
REQ-029 Reset SHALL force IDLE immediately, including mid-ACCESS; all registered outputs/captures 0; o_bus_req drops asynchronously.
REQ-030 After reset release, first edge with a request SHALL start a fresh access.

Configuration
REQ-031 Macro LSU_TIMEOUT_EN defined: counter counts ACCESS cycles; after TIMEOUT_CYC cycles without ack -> DONE with o_lsu_exc=1, o_ld_data=0; counter clears on entering ACCESS.
REQ-032 LSU_TIMEOUT_EN undefined: ACCESS waits indefinitely for ack; no counter logic; exceptions only from REQ-016.

Structure
REQ-033 Package lsu_pkg SHALL hold state enum, funct3 width localparams, bus width constants.
REQ-034 Combinational sub-module lsu_ld_align SHALL perform lane select and extension.

Verification
REQ-035 LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> be 1111, stall 4 cycles, ld_data 0xDEADBEEF.
REQ-036 LB addr 0x103, rdata 0x80FF_FF00 -> be 1000, ld_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x202, st_data 0x1234ABCD -> be 1100, wdata 0xABCDABCD, we=1, ld_vld=0.
REQ-038 LW addr 0x101 -> no bus_req, DONE next cycle, o_lsu_exc=1, ld_data 0.
REQ-039 Reset asserted during ACCESS -> bus_req 0 immediately, state IDLE; late ack ignored.
REQ-040 With LSU_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> exc=1 after 4 ACCESS cycles; without macro, still waiting at cycle 100.
